// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op and state encodings for the multiply/divide unit
package cpu_pkg;

    // Operation select driven by uControl
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states of the iterative unit
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    // True for the two divide encodings
    function automatic logic md_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    // True for the two signed encodings
    function automatic logic md_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - shift-add / restoring shift-subtract working registers
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_abs,
    input  logic [WIDTH-1:0] b_abs,
    input  logic             neg_prod,
    input  logic             neg_quot,
    input  logic             neg_rem,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc_hi: product upper half / partial remainder
    // acc_lo: multiplier being consumed / dividend shifting out, quotient shifting in
    // m:      multiplicand / divisor
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   m_q, m_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Multiply step: add the multiplicand into the upper half when the low multiplier bit is set
    always_comb begin
        mul_sum = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) begin
            mul_sum = {1'b0, acc_hi_q} + {1'b0, m_q};
        end
    end

    // Divide step: the trial remainder carries one extra bit so the compare never wraps;
    // when it succeeds the difference is below the divisor, so WIDTH bits hold it exactly
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, m_q};
    assign div_diff  = div_shift[WIDTH-1:0] - m_q;

    // Next working-register values: capture on load, one bit of progress per step
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        if (load) begin
            acc_hi_d = '0;
            acc_lo_d = is_div ? a_abs : b_abs;
            m_d      = is_div ? b_abs : a_abs;
        end else if (step) begin
            if (is_div) begin
                acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    // Working register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
        end
    end

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_prod ? (~prod + 1'b1) : prod;

    // Sign-corrected results presented to the HI/LO writeback
    always_comb begin
        if (is_div) begin
            res_lo = neg_quot ? (~acc_lo_q + 1'b1) : acc_lo_q;
            res_hi = neg_rem  ? (~acc_hi_q + 1'b1) : acc_hi_q;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO pair
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             div0_q, div0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    md_op_e           op_in;
    logic             in_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             dp_load;
    logic             dp_step;
    logic             neg_prod;
    logic             neg_quot;
    logic             neg_rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign op_in     = md_op_e'(op);
    assign in_signed = md_is_signed(op_in);
    assign a_abs     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Unsigned ops never have their sign flags set, so these are zero for them
    assign neg_prod = (op_q == MD_MULT) && (sa_q ^ sb_q);
    assign neg_quot = (op_q == MD_DIV)  && (sa_q ^ sb_q);
    assign neg_rem  = (op_q == MD_DIV)  && sa_q;

    md_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (reset),
        .load     (dp_load),
        .step     (dp_step),
        .is_div   (md_is_div(op_d)),
        .a_abs    (a_abs),
        .b_abs    (b_abs),
        .neg_prod (neg_prod),
        .neg_quot (neg_quot),
        .neg_rem  (neg_rem),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    // Sequencer next state, operand capture, HI/LO writeback and cancel override
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div0_d  = div0_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_d  = op_in;
                    sa_d  = in_signed & a[WIDTH-1];
                    sb_d  = in_signed & b[WIDTH-1];
                    cnt_d = CNT_W'(WIDTH);
                    if (md_is_div(op_in) && (b == '0)) begin
                        div0_d  = 1'b1;
                        state_d = MD_DONE;
                    end else begin
                        div0_d  = 1'b0;
                        dp_load = 1'b1;
                        state_d = MD_CALC;
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            MD_CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                // Results land on the edge into DONE so they are visible alongside done
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = MD_DONE;
            end
            MD_DONE: begin
                div0_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
        // An exception abandons whatever is in flight without touching HI/LO
        if (cancel && (state_q != MD_IDLE)) begin
            state_d = MD_IDLE;
            dp_step = 1'b0;
            div0_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // Sequencer and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div0_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div0_q  <= div0_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign done = (state_q == MD_DONE) && !cancel;
    assign div0 = done && div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, cancel, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .cancel(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
    );

    int          checks = 0;
    int          fails = 0;
    exp_t        sb32[$];
    exp_t        sb8[$];
    exp_t        e32, e8;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    logic [31:0] m8hi = 32'd0, m8lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on sign-interpreted operands, reduced modulo 2^w
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input int w, input logic [31:0] ch, input logic [31:0] cl);
        exp_t        e;
        logic [63:0] mask, ux, uy, p;
        longint      sx, sy;
        mask = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & mask;
        uy = {32'd0, y} & mask;
        sx = longint'(ux);
        sy = longint'(uy);
        if (ux[w-1]) sx = sx - (longint'(1) << w);
        if (uy[w-1]) sy = sy - (longint'(1) << w);
        e.div0 = 1'b0;
        e.hi = ch;
        e.lo = cl;
        case (o)
            2'b00: begin p = sx * sy; e.hi = 32'((p >> w) & mask); e.lo = 32'(p & mask); end
            2'b01: begin p = ux * uy; e.hi = 32'((p >> w) & mask); e.lo = 32'(p & mask); end
            2'b10: begin
                if (uy == 64'd0) e.div0 = 1'b1;
                else begin
                    p = sx / sy; e.lo = 32'(p & mask);
                    p = sx % sy; e.hi = 32'(p & mask);
                end
            end
            default: begin
                if (uy == 64'd0) e.div0 = 1'b1;
                else begin e.lo = 32'(ux / uy); e.hi = 32'(ux % uy); end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb32.size() == 0) chk("w32_unexpected_done", 32'(done), 32'd0);
            else begin
                e32 = sb32.pop_front();
                chk("w32_hi", hi, e32.hi);
                chk("w32_lo", lo, e32.lo);
                chk("w32_div0", 32'(div0), 32'(e32.div0));
            end
        end
        if (rst_n && done8) begin
            if (sb8.size() == 0) chk("w8_unexpected_done", 32'(done8), 32'd0);
            else begin
                e8 = sb8.pop_front();
                chk("w8_hi", 32'(hi8), e8.hi);
                chk("w8_lo", 32'(lo8), e8.lo);
                chk("w8_div0", 32'(div08), 32'(e8.div0));
            end
        end
    end

    // Issue one op from IDLE; optionally poke start/MTHI/MTLO mid-flight to prove they are ignored
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
        exp_t e;
        int   n, lat;
        logic busy_ok;
        e = model(o, x, y, 32, mhi, mlo);
        sb32.push_back(e);
        if (!e.div0) begin mhi = e.hi; mlo = e.lo; end
        lat = e.div0 ? 1 : 34;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            busy_ok = busy_ok & busy;
            if (n == poke) begin
                start = 1'b1; op = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        chk("busy_during_op", 32'(busy_ok & busy), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_cancel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int at);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < at) begin @(negedge clk); n++; end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_hi", hi, mhi);
        chk("cancel_lo", lo, mlo);
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        hi_we = hw; lo_we = lw; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) mhi = d;
        if (lw) mlo = d;
        chk("mt_hi", hi, mhi);
        chk("mt_lo", lo, mlo);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   n, lat;
        e = model(o, {24'd0, x}, {24'd0, y}, 8, m8hi, m8lo);
        sb8.push_back(e);
        if (!e.div0) begin m8hi = e.hi; m8lo = e.lo; end
        lat = e.div0 ? 1 : 10;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin @(negedge clk); n++; end
        chk("w8_latency", 32'(n), 32'(lat));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] x, y;
        int          r;
        start = 0; cancel = 0; hi_we = 0; lo_we = 0; op = 0; a = 0; b = 0; wdata = 0;
        start8 = 0; op8 = 0; a8 = 0; b8 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_cancel(2'b01, $urandom, $urandom, 10);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        mt(1'b1, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(9, 0);
            x = pick();
            y = pick();
            if (r == 0) mt(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
            else if (r == 1) run_cancel(2'($urandom_range(3, 0)), x, y | 32'd1, $urandom_range(33, 1));
            else run_op(2'($urandom_range(3, 0)), x, y, (r == 2) ? $urandom_range(30, 1) : 0);
        end

        // Asynchronous reset in the middle of CALC, between clock edges
        mt(1'b1, 1'b1, 32'h5A5A_5A5A);
        op = 2'b01; a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        mhi = 32'd0; mlo = 32'd0; m8hi = 32'd0; m8lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run8(2'b01, 8'hFF, 8'hFF);
        run8(2'b00, 8'hFD, 8'h07);
        run8(2'b10, 8'h80, 8'hFF);
        run8(2'b11, 8'h10, 8'h00);
        for (int i = 0; i < 20; i++) begin
            run8(2'($urandom_range(3, 0)), 8'($urandom), ($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom));
        end

        chk("sb32_drained", 32'(sb32.size()), 32'd0);
        chk("sb8_drained", 32'(sb8.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the multicycle CPU datapath.
- Replaces single-width, fixed-function HILO handling with the following features:
  - configurable operand WIDTH;
  - signed and unsigned modes;
  - a start/busy/done handshake;
  - cancel on exception;
  - direct HI/LO writes (MTHI/MTLO).
- Sits beside the ALU. uControl drives start, op and cancel, and waits on done; div0 feeds the exception logic.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; captured when start is accepted.
- b  in  WIDTH  multiplier / divisor; captured when start is accepted.
- cancel  in  1  abort the operation in flight; HI/LO are left unchanged.
- hi_we  in  1  direct write of HI (MTHI).
- lo_we  in  1  direct write of LO (MTLO).
- wdata  in  WIDTH  data for hi_we / lo_we.
- busy  out  1  high while an operation is in flight (not IDLE).
- done  out  1  one-cycle pulse when HI/LO are updated or div0 is reported.
- div0  out  1  one-cycle pulse, coincident with done, for a divide by zero.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE;
  - hi, lo, counter and working registers = 0;
  - busy, done and div0 = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 captures op, |a| and |b| (absolute values only for signed ops), and the operand sign bits; counter = WIDTH.
  - Divide with b==0: go to DONE with a div0 flag set.
  - Otherwise: go to CALC.
- CALC, one bit per cycle, counter decrements:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder kept WIDTH+1 bits wide.
  - When counter reaches 1, the next state is FIX.
- FIX (1 cycle): sign correction.
  - Signed multiply: negate the 2*WIDTH product if sign(a)^sign(b).
  - Signed divide: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - Then go to DONE.
- DONE (1 cycle):
  - done=1.
  - hi/lo are written on entry to DONE, so the new values are visible in the same cycle as done.
  - div0 case: div0=1 and hi/lo are not modified.
  - Next state IDLE.
- Latency: start accepted in cycle T → done high in cycle T+WIDTH+2; busy=1 from T+1 through T+WIDTH+2 inclusive. div0 path: done and div0 in T+1.
- Back-to-back: a new start is accepted in the cycle after done.
- start outside IDLE is ignored; the captured operands are not disturbed.
- cancel=1 in CALC/FIX/DONE: next state IDLE, no done, hi/lo unchanged. cancel in IDLE has no effect. cancel has priority over start in the same cycle.
- hi_we/lo_we:
  - Honoured only when IDLE and start=0; ignored otherwise. Software must not issue MTHI/MTLO during an operation.
  - Both may assert together (both registers get wdata).
- Signed overflow, MIN_INT / -1: quotient = MIN_INT, remainder = 0. No trap, no div0.
- Unsigned ops: no FIX correction (FIX is still spent as one cycle so latency is identical for every op).
- All arithmetic is modulo 2^WIDTH per half.

Decomposition:
- Shared package cpu_pkg:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum values MD_IDLE, MD_CALC, MD_FIX, MD_DONE.
- One natural sub-module: md_datapath. It holds the accumulator/remainder registers and the shift-add/subtract step logic, controlled by the FSM in mult_div_unit.

Test Plan:
- MULTU, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF → done at T+34 with hi=0xFFFFFFFE, lo=0x00000001; busy high for 34 cycles.
- MULT signed: a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV signed: a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU: a=100, b=7 → lo=14, hi=2.
- DIV with b=0, after preloading hi=0x11, lo=0x22 via hi_we/lo_we → done and div0 at T+1; hi=0x11, lo=0x22 unchanged. DIV MIN_INT/-1 → lo=0x80000000, hi=0, div0=0.
- Cancel at cycle T+10 of a MULTU → no done pulse, busy=0 at T+11, hi/lo retain prior values. A start asserted during CALC is ignored and the first result is delivered intact.
- Async reset asserted mid-CALC, with no clock edge → busy, done, hi and lo go to 0 immediately. Re-run with WIDTH=8: MULTU 0xFF*0xFF → hi=0xFE, lo=0x01 at T+10.
